// File: rtl/wavetable_oscillator.sv
// Direct-digital-synthesis wavetable oscillator: one signed sample per MCLK_DIV-cycle frame,
// produced by a phase accumulator and a 3-stage waveform pipeline, delivered over valid/ready.
module wavetable_oscillator #(
    parameter int SAMPLE_BITS   = 16,
    parameter int PHASE_BITS    = 24,
    parameter int LUT_ADDR_BITS = 8,
    parameter int MCLK_DIV      = 256
) (
    input  logic                          mclk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [PHASE_BITS-1:0]         freq_word,
    input  logic [1:0]                    wave_sel,
    output logic signed [SAMPLE_BITS-1:0] sample_out,
    output logic                          sample_valid,
    input  logic                          sample_ready,
    output logic                          overrun,
    input  logic                          overrun_clr
);

    localparam int  CNT_W     = (MCLK_DIV > 1) ? $clog2(MCLK_DIV) : 1;
    localparam int  LUT_DEPTH = 1 << LUT_ADDR_BITS;
    localparam int  ROM_W     = SAMPLE_BITS - 1;
    localparam int  TOP_W     = SAMPLE_BITS + 1;
    localparam real PI        = 3.14159265358979323846;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MCLK_DIV - 1);

    // Quarter-wave magnitudes, sampled at the centre of each LUT bin so the fold is symmetric.
    function automatic logic [LUT_DEPTH*ROM_W-1:0] build_rom();
        logic [LUT_DEPTH*ROM_W-1:0] rom;
        real amp;
        real x;
        rom = '0;
        amp = real'((1 << (SAMPLE_BITS - 1)) - 1);
        for (int i = 0; i < LUT_DEPTH; i++) begin
            x = amp * $sin(PI / 2.0 * (real'(i) + 0.5) / real'(LUT_DEPTH));
            rom[i*ROM_W +: ROM_W] = ROM_W'($rtoi(x + 0.5));
        end
        return rom;
    endfunction

    localparam logic [LUT_DEPTH*ROM_W-1:0] SINE_ROM = build_rom();

    function automatic logic [ROM_W-1:0] sine_mag(input logic q_odd,
                                                  input logic [LUT_ADDR_BITS-1:0] idx);
        logic [LUT_ADDR_BITS-1:0] a;
        a = q_odd ? ~idx : idx;
        return SINE_ROM[int'(a)*ROM_W +: ROM_W];
    endfunction

    // top holds the phase MSB followed by u, the SAMPLE_BITS bits just below it.
    function automatic logic signed [SAMPLE_BITS-1:0] shape(input logic [1:0]       sel,
                                                            input logic             en,
                                                            input logic [TOP_W-1:0] top,
                                                            input logic [ROM_W-1:0] mag);
        logic signed [SAMPLE_BITS-1:0] amp;
        logic signed [SAMPLE_BITS-1:0] centred;
        logic signed [SAMPLE_BITS-1:0] res;
        amp     = {1'b0, {(SAMPLE_BITS-1){1'b1}}};
        centred = {~top[SAMPLE_BITS-1], top[SAMPLE_BITS-2:0]};
        case (sel)
            2'd0:    res = top[SAMPLE_BITS] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
            2'd1:    res = top[SAMPLE_BITS] ? -amp : amp;
            2'd2:    res = {~top[SAMPLE_BITS], top[SAMPLE_BITS-1:1]};
            default: res = top[SAMPLE_BITS] ? ~centred : centred;
        endcase
        if (!en) res = '0;
        return res;
    endfunction

    logic [CNT_W-1:0]              frame_cnt;
    logic                          tick;
    logic [PHASE_BITS-1:0]         phase;
    logic                          vld_p0, vld_p1, vld_p2;
    logic [TOP_W-1:0]              top_p0, top_p1;
    logic [1:0]                    sel_p0, sel_p1;
    logic                          en_p0, en_p1;
    logic [ROM_W-1:0]              mag_p1;
    logic signed [SAMPLE_BITS-1:0] sample_p2;

    assign tick = (frame_cnt == CNT_LAST);

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            phase     <= '0;
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
        end else begin
            frame_cnt <= tick ? '0 : frame_cnt + CNT_W'(1);
            vld_p0    <= tick;
            vld_p1    <= vld_p0;
            vld_p2    <= vld_p1;
            if (tick) phase <= enable ? phase + freq_word : '0;
        end
    end

    always_ff @(posedge mclk) begin
        // p0: capture pre-increment phase and controls at the tick only
        if (tick) begin
            top_p0 <= phase[PHASE_BITS-1 -: TOP_W];
            sel_p0 <= wave_sel;
            en_p0  <= enable;
        end
        // p1: quarter-wave ROM read
        top_p1 <= top_p0;
        sel_p1 <= sel_p0;
        en_p1  <= en_p0;
        mag_p1 <= sine_mag(top_p0[SAMPLE_BITS-1], top_p0[SAMPLE_BITS-2 -: LUT_ADDR_BITS]);
        // p2: waveform shaping and sign
        sample_p2 <= shape(sel_p1, en_p1, top_p1, mag_p1);
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            sample_out   <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (vld_p2) begin
                sample_out   <= sample_p2;
                sample_valid <= 1'b1;
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
            if (overrun_clr)
                overrun <= 1'b0;
            else if (vld_p2 && sample_valid && !sample_ready)
                overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wavetable_oscillator.sv
// Bench for wavetable_oscillator: vector table, randomized frames against a phase/waveform
// model, and hand-written handshake and reset sequences.
module tb_wavetable_oscillator;

    logic               mclk;
    logic               rst_n;
    logic               enable;
    logic [23:0]        freq_word;
    logic [1:0]         wave_sel;
    logic signed [15:0] sample_out;
    logic               sample_valid;
    logic               sample_ready;
    logic               overrun;
    logic               overrun_clr;

    wavetable_oscillator dut (
        .mclk         (mclk),
        .rst_n        (rst_n),
        .enable       (enable),
        .freq_word    (freq_word),
        .wave_sel     (wave_sel),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    typedef struct {
        bit          en;
        logic [1:0]  sel;
        logic [23:0] fw;
        int          exp;
    } vec_t;

    vec_t vecs[$];
    int   n_checks;
    int   n_fail;
    int   model_phase;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input bit en, input logic [1:0] sel, input logic [23:0] fw, input int exp);
        vec_t v;
        v.en = en; v.sel = sel; v.fw = fw; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic wait_valid(input int budget, output int cycles, output bit got);
        cycles = 0;
        got    = 1'b0;
        while (cycles < budget && !got) begin
            @(posedge mclk);
            #1;
            cycles++;
            if (sample_valid) got = 1'b1;
        end
    endtask

    // Reference waveform from the phase p (24 bits) captured at the tick.
    function automatic int ref_sample(input int sel, input bit en, input int p);
        int  m, u, q, idx, v;
        real r;
        if (!en) return 0;
        m = (p >> 23) & 1;
        u = (p >> 7) & 'hFFFF;
        case (sel)
            0: begin
                q   = (p >> 22) & 3;
                idx = (p >> 14) & 255;
                if (q % 2 == 1) idx = 255 - idx;
                r = 32767.0 * $sin(3.14159265358979323846 / 2.0 * (real'(idx) + 0.5) / 256.0);
                v = $rtoi(r + 0.5);
                return (q >= 2) ? -v : v;
            end
            1: return (m == 0) ? 32767 : -32767;
            2: return ((p >> 8) & 'hFFFF) - 32768;
            default: return (m == 0) ? u - 32768 : 32767 - u;
        endcase
    endfunction

    function automatic int next_phase(input int p, input bit en, input int fw);
        return en ? ((p + fw) & 'hFFFFFF) : 0;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        bit got;
        int exp;
        bit x_en;
        int x_sel;
        int x_fw;

        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b1; enable = 1'b1; wave_sel = 2'd0; freq_word = 24'h400000;
        sample_ready = 1'b1; overrun_clr = 1'b0;
        #3 rst_n = 1'b0;
        repeat (3) @(posedge mclk);
        #1;
        check("reset_sample_out", sample_out, 0);
        check("reset_valid", sample_valid, 0);
        check("reset_overrun", overrun, 0);

        add(1, 2'd0, 24'h400000, 101);
        add(1, 2'd0, 24'h400000, 32767);
        add(1, 2'd0, 24'h400000, -101);
        add(1, 2'd0, 24'h400000, -32767);
        add(1, 2'd1, 24'h800000, 32767);
        add(1, 2'd1, 24'h800000, -32767);
        add(1, 2'd3, 24'h200000, -32768);
        add(1, 2'd3, 24'h200000, -16384);
        add(1, 2'd3, 24'h200000, 0);
        add(1, 2'd3, 24'h200000, 16384);
        add(1, 2'd3, 24'h200000, 32767);
        add(1, 2'd3, 24'h200000, 16383);
        add(1, 2'd3, 24'h200000, -1);
        add(1, 2'd3, 24'h200000, -16385);
        add(1, 2'd0, 24'h400000, 101);
        add(0, 2'd0, 24'h400000, 0);
        add(1, 2'd0, 24'h400000, 101);
        add(0, 2'd2, 24'h100000, 0);
        for (int k = 0; k < 16; k++) add(1, 2'd2, 24'h100000, -32768 + 4096 * k);
        add(1, 2'd2, 24'h100000, -32768);

        model_phase = 0;
        @(negedge mclk);
        enable = vecs[0].en; wave_sel = vecs[0].sel; freq_word = vecs[0].fw;
        rst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            enable = vecs[i].en; wave_sel = vecs[i].sel; freq_word = vecs[i].fw;
            wait_valid(300, cyc, got);
            check($sformatf("table_valid[%0d]", i), got, 1);
            check($sformatf("table_period[%0d]", i), cyc, (i == 0) ? 259 : 256);
            check($sformatf("table_sample[%0d]", i), sample_out, vecs[i].exp);
            model_phase = next_phase(model_phase, vecs[i].en, int'(vecs[i].fw));
        end

        // Randomized frames; inputs are scrambled while each sample is in flight.
        for (int i = 0; i < 40; i++) begin
            x_en  = ($urandom_range(0, 7) != 0);
            x_sel = int'($urandom_range(0, 3));
            x_fw  = int'($urandom & 32'hFFFFFF);
            if (i % 10 == 3) x_fw = 0;
            enable = x_en; wave_sel = 2'(x_sel); freq_word = 24'(x_fw);
            repeat (254) @(posedge mclk);
            #1;
            check($sformatf("rand_idle_valid[%0d]", i), sample_valid, 0);
            exp = ref_sample(x_sel, x_en, model_phase);
            model_phase = next_phase(model_phase, x_en, x_fw);
            enable = 1'($urandom_range(0, 1));
            wave_sel = 2'($urandom_range(0, 3));
            freq_word = 24'($urandom);
            wait_valid(8, cyc, got);
            check($sformatf("rand_latency[%0d]", i), got ? cyc : -1, 2);
            check($sformatf("rand_sample[%0d] sel=%0d", i, x_sel), sample_out, exp);
        end

        // Overrun, clear priority and accept-on-landing.
        enable = 1'b1; wave_sel = 2'd0; freq_word = 24'h400000; sample_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge mclk);
        @(negedge mclk) rst_n = 1'b1;
        wait_valid(300, cyc, got);
        check("ovr_first_latency", got ? cyc : -1, 259);
        check("ovr_first_sample", sample_out, 101);
        sample_ready = 1'b0;
        repeat (255) @(posedge mclk);
        #1;
        check("ovr_held_valid", sample_valid, 1);
        check("ovr_held_sample", sample_out, 101);
        check("ovr_before_set", overrun, 0);
        @(posedge mclk);
        #1;
        check("ovr_set", overrun, 1);
        check("ovr_overwritten_sample", sample_out, 32767);
        check("ovr_valid_kept", sample_valid, 1);
        overrun_clr = 1'b1;
        @(posedge mclk);
        #1;
        overrun_clr = 1'b0;
        check("ovr_cleared", overrun, 0);
        repeat (254) @(posedge mclk);
        #1;
        overrun_clr = 1'b1;
        @(posedge mclk);
        #1;
        overrun_clr = 1'b0;
        check("ovr_clr_priority", overrun, 0);
        check("ovr_clr_sample", sample_out, -101);
        repeat (255) @(posedge mclk);
        #1;
        sample_ready = 1'b1;
        @(posedge mclk);
        #1;
        check("land_accept_valid", sample_valid, 1);
        check("land_accept_sample", sample_out, -32767);
        check("land_accept_overrun", overrun, 0);
        @(posedge mclk);
        #1;
        check("land_accept_drain", sample_valid, 0);

        // Reset one cycle after a tick, with a sample held and another in flight.
        sample_ready = 1'b0;
        repeat (255) @(posedge mclk);
        #1;
        check("mid_held_valid", sample_valid, 1);
        check("mid_held_sample", sample_out, 101);
        repeat (254) @(posedge mclk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_sample_out", sample_out, 0);
        check("async_rst_valid", sample_valid, 0);
        check("async_rst_overrun", overrun, 0);
        sample_ready = 1'b1;
        @(negedge mclk) rst_n = 1'b1;
        wait_valid(300, cyc, got);
        check("post_rst_latency", got ? cyc : -1, 259);
        check("post_rst_sample", sample_out, 101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wavetable_oscillator.md
Name: wavetable_oscillator

Overview:
- Direct-digital-synthesis sample source that sits upstream of the I2S transmitter, entirely in the mclk domain.
- Generates one signed SAMPLE_BITS sample per audio frame, i.e. every MCLK_DIV mclk cycles.
- Waveform is selectable: sine (quarter-wave ROM), square, saw or triangle. Pitch is set by a phase-accumulator tuning word.
- Each sample is delivered through a valid/ready handshake, so the transmitter (or a buffer-fill stage) consumes exactly one sample per frame.

Parameters:
- SAMPLE_BITS, 16, output sample width (signed two's complement).
- PHASE_BITS, 24, phase accumulator width. Pitch = fs * freq_word / 2^PHASE_BITS.
- LUT_ADDR_BITS, 8, quarter-wave sine ROM address width (256 entries).
- MCLK_DIV, 256, mclk cycles per sample frame.

Ports:
- mclk  input  1  master clock, sole clock; all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  1 = oscillate; 0 = phase held at 0 and silence emitted.
- freq_word  input  PHASE_BITS  phase increment per sample, sampled at tick.
- wave_sel  input  2  0 sine, 1 square, 2 saw, 3 triangle; sampled at tick.
- sample_out  output  SAMPLE_BITS  signed sample; stable while sample_valid=1.
- sample_valid  output  1  sample_out holds an unconsumed sample.
- sample_ready  input  1  consumer accepts on posedge when valid&ready.
- overrun  output  1  sticky: an unconsumed sample was overwritten.
- overrun_clr  input  1  synchronous clear of overrun.

Behaviour:
- Reset (async assert, sync release): frame counter=0, phase=0, pipeline valids=0, sample_out=0, sample_valid=0, overrun=0.
- Frame counter:
  - Counts 0..MCLK_DIV-1 and wraps.
  - tick=1 for the single cycle where counter==MCLK_DIV-1.
  - First tick occurs MCLK_DIV cycles after reset release.
- On tick:
  - Stage 1 captures p = current phase, wave_sel, enable.
  - phase <= enable ? phase+freq_word (mod 2^PHASE_BITS) : 0.
  - The emitted sample therefore uses the pre-increment phase.
- Pipeline: 3 registered stages (decode/capture, ROM read, shape/sign). sample_out and sample_valid update on the 3rd posedge after the tick edge.
- Waveform math, with u = p[PHASE_BITS-2 -: SAMPLE_BITS] and m = p MSB:
  - Sine:
    - quadrant q = top 2 bits; idx = next LUT_ADDR_BITS bits.
    - q odd -> idx = ~idx.
    - ROM[i] = round(32767*sin(pi/2*(i+0.5)/256)).
    - q>=2 -> negate.
    - Range is ±32767; -32768 is never produced.
  - Square: m=0 -> +32767, else -32767.
  - Saw: p top SAMPLE_BITS bits with MSB inverted (0 -> -32768, max -> +32767).
  - Triangle: m=0 -> u-32768; m=1 -> 32767-u.
  - enable=0 at capture -> sample value 0.
- Handshake:
  - Accept = sample_valid & sample_ready at posedge; sample_valid then drops unless a new result lands the same cycle.
  - New result landing while sample_valid=1 and no accept: sample_out overwritten, overrun<=1.
  - New result with simultaneous accept: load new sample, valid stays 1, no overrun.
  - overrun_clr has priority over a same-cycle set.
- Changes to freq_word/wave_sel between ticks have no effect until the next tick. Mid-frame changes never corrupt an in-flight sample.
- Reset mid-pipeline: all in-flight samples are discarded; no valid is emitted until a fresh tick has propagated.

Test Plan:
- Reset then idle, ready=1, enable=1, wave_sel=0, freq_word=2^22:
  - first valid at cycle 256+3 after release, recurring every 256 cycles.
  - Samples are 101, 32767, -101, -32767, then repeat.
- wave_sel=2, freq_word=2^20, ready=1 -> samples -32768, -28672, -24576, … stepping +4096. After wrap, returns to -32768 on the 17th sample.
- wave_sel=1, freq_word=2^23 -> alternating +32767, -32767. wave_sel=3 with freq_word=2^21 -> -32768, 0, 32767 (u=65535 case excluded: check 0x7FFF→32767-…) per computed triangle values; compare against a reference model.
- Hold sample_ready=0 across two ticks -> overrun=1, sample_out equals the second sample, valid held. Pulse overrun_clr -> overrun=0 next cycle. Ready asserted on the exact cycle a new sample lands -> no overrun.
- Deassert enable mid-stream -> next sample is 0 and phase resets. Re-enable -> sequence restarts from the phase-0 value (101 for sine).
- Assert rst_n=0 one cycle after a tick -> outputs 0 immediately (async). After release, no valid for 256+3 cycles.
